// File: rtl/sweep_pkg.sv
// Shared types and limits for the function sweep checker.
// Holds the sweep FSM state encoding, parameter bounds and defaults.
// No logic; imported by the checker and its settle timer.
package sweep_pkg;

  localparam int N_MAX          = 8;
  localparam int SETTLE_MAX     = 15;
  localparam int N_DEFAULT      = 3;
  localparam int SETTLE_DEFAULT = 1;

  // Width of the settle down-counter, sized for SETTLE_MAX.
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle down-counter: loaded with the settle length when a new vector is applied.
// Latency: expire_o is combinational from the count, high in the last settle cycle.
// No backpressure; count_i simply gates the decrement.
module sweep_settle_timer
  import sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                count_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  output logic                expire_o
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement while counting, never below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means this is the final settle cycle.
  assign expire_o = count_i && (cnt_q <= SETTLE_W'(1));

endmodule

// File: rtl/function_sweep_checker.sv
// Exhaustively sweeps x over all 2**N vectors and compares f_in against a latched golden truth table.
// Latency: SETTLE+1 cycles per vector; done pulses 1+2**N*(SETTLE+1) cycles after start is accepted.
// No backpressure; start is only honoured in IDLE. Optional SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module function_sweep_checker
  import sweep_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [(1<<N)-1:0]   golden,
  input  logic                f_in,
  output logic [N-1:0]        x,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N:0]          err_cnt,
  output logic [N-1:0]        first_fail,
  output logic                fail_valid
);

  localparam int                  NV        = 1 << N;
  localparam logic [N-1:0]        X_LAST    = {N{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);
  // With no settle time each new vector is compared in the very next cycle.
  localparam state_e              VEC_ENTRY = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;

  state_e          state_q, state_d;
  logic [N-1:0]    x_q, x_d;
  logic [NV-1:0]   gold_q, gold_d;
  logic [N:0]      err_q, err_d;
  logic [N-1:0]    ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            pass_q, pass_d;
  logic            settle_load;
  logic            settle_expire;
  logic            mismatch;
  logic            stop_early;

  sweep_settle_timer u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (settle_load),
    .count_i    (state_q == ST_SETTLE),
    .load_val_i (SETTLE_LD),
    .expire_o   (settle_expire)
  );

  assign mismatch = (f_in != gold_q[x_q]);

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  // Sweep sequencing: next state, stimulus vector and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    gold_d      = gold_q;
    err_d       = err_q;
    ff_d        = ff_q;
    fv_d        = fv_q;
    pass_d      = pass_q;
    settle_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          gold_d      = golden;
          err_d       = '0;
          ff_d        = '0;
          fv_d        = 1'b0;
          pass_d      = 1'b0;
          x_d         = '0;
          state_d     = VEC_ENTRY;
          settle_load = (SETTLE != 0);
        end
      end
      ST_SETTLE: begin
        if (settle_expire) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            ff_d = x_q;
            fv_d = 1'b1;
          end
        end
        if ((x_q == X_LAST) || stop_early) begin
          // x is left on the last compared vector; it never wraps.
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          x_d         = x_q + 1'b1;
          state_d     = VEC_ENTRY;
          settle_load = (SETTLE != 0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      gold_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      gold_q  <= gold_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  assign x          = x_q;
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_function_sweep_checker.sv
// Bench for function_sweep_checker: random and directed truth-table sweeps against a table-walk model.
// Two instances: N=3/SETTLE=1 and N=1/SETTLE=0.
// Inputs change away from the rising edge; outputs are sampled on the falling edge.
module tb_function_sweep_checker;

  localparam int N  = 3;
  localparam int S  = 1;
  localparam int NV = 1 << N;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          start  = 1'b0;
  logic [NV-1:0] golden = '0;
  logic          f_in   = 1'b0;
  logic [N-1:0]  x;
  logic          busy, done, pass, fail_valid;
  logic [N:0]    err_cnt;
  logic [N-1:0]  first_fail;

  logic          start_b  = 1'b0;
  logic [1:0]    golden_b = 2'b10;
  logic          f_in_b;
  logic [0:0]    x_b;
  logic          busy_b, done_b, pass_b, fail_valid_b;
  logic [1:0]    err_cnt_b;
  logic [0:0]    first_fail_b;

  int            n_cmp   = 0;
  int            n_bad   = 0;
  int            cyc     = 0;
  int            acc_cyc = 0;
  bit            sweeping = 1'b0;
  logic [NV-1:0] resp    = '0;

  function_sweep_checker #(.N(N), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .golden(golden), .f_in(f_in),
    .x(x), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail(first_fail), .fail_valid(fail_valid)
  );

  function_sweep_checker #(.N(1), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .golden(golden_b), .f_in(f_in_b),
    .x(x_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_cnt_b),
    .first_fail(first_fail_b), .fail_valid(fail_valid_b)
  );

  // Ideal identity function for the small instance.
  assign f_in_b = x_b[0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Function under test: resp[x] in compare cycles, random noise in settle cycles.
  always @(posedge clk) begin
    #2;
    if (sweeping && (((cyc - acc_cyc) % (S + 1)) != S)) f_in = 1'($urandom);
    else f_in = resp[x];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic accept_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    acc_cyc  = cyc;
    sweeping = 1'b1;
  endtask

  // Full sweep on the main instance with the expected results taken from walking the tables.
  task automatic run_sweep(input logic [NV-1:0] g, input logic [NV-1:0] r, input bit repulse);
    int e = 0;
    int ff = 0;
    int last = NV - 1;
    int waited = 0;
    bit fv = 1'b0;
    int lat;
    for (int i = 0; i < NV; i++) begin
      if (g[i] !== r[i]) begin
        e++;
        if (!fv) begin
          fv = 1'b1;
          ff = i;
        end
      end
`ifdef SWEEP_STOP_ON_FAIL_EN
      if (fv) begin
        last = i;
        break;
      end
`endif
    end
    lat    = (last + 1) * (S + 1);
    resp   = r;
    golden = g;
    accept_start();
    golden = NV'($urandom);
    @(negedge clk);
    check("busy_start", busy, 1);
    while (!done && waited < 200) begin
      start = repulse && ((cyc - acc_cyc) == 4);
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("done_latency", cyc - acc_cyc, lat);
    check("pass", pass, int'(e == 0));
    check("err_cnt", err_cnt, e);
    check("fail_valid", fail_valid, fv);
    check("first_fail", first_fail, ff);
    check("x_last", x, last);
    check("busy_done", busy, 0);
    if (repulse) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("pass_hold", pass, int'(e == 0));
    check("x_hold", x, last);
    repeat (2) @(negedge clk);
    check("busy_idle", busy, 0);
    check("no_second_done", done, 0);
    sweeping = 1'b0;
  endtask

  // Sweep on the N=1, SETTLE=0 instance with f = x.
  task automatic run_small(input logic [1:0] g);
    int e = 0;
    int ff = 0;
    int last = 1;
    int waited = 0;
    int ab;
    bit fv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (g[i] !== i[0]) begin
        e++;
        if (!fv) begin
          fv = 1'b1;
          ff = i;
        end
      end
`ifdef SWEEP_STOP_ON_FAIL_EN
      if (fv) begin
        last = i;
        break;
      end
`endif
    end
    golden_b = g;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b  = 1'b0;
    ab       = cyc;
    golden_b = ~g;
    @(negedge clk);
    while (!done_b && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("b_done_seen", done_b, 1);
    check("b_done_latency", cyc - ab, last + 1);
    check("b_pass", pass_b, int'(e == 0));
    check("b_err_cnt", err_cnt_b, e);
    check("b_fail_valid", fail_valid_b, fv);
    check("b_first_fail", first_fail_b, ff);
    check("b_x_last", x_b, last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_bad %0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NV-1:0] g, r;
    #1 rst_n = 1'b0;
    #2;
    check("rst_x", x, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_ff", first_fail, 0);
    check("rst_fv", fail_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Majority function, ideal and stuck-at-0, then start re-pulsed mid-sweep and on done.
    run_sweep(8'b1110_1000, 8'b1110_1000, 1'b0);
    run_sweep(8'b1110_1000, 8'b0000_0000, 1'b0);
    run_sweep(8'b1110_1000, 8'b1110_1000, 1'b1);

    // Reset in the middle of a failing sweep.
    resp   = '0;
    golden = 8'b1110_1000;
    accept_start();
    do @(negedge clk); while ((cyc - acc_cyc) < 8);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_fv", fail_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", x, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_err", err_cnt, 0);
    check("mid_rst_ff", first_fail, 0);
    check("mid_rst_fv", fail_valid, 0);
    sweeping = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    run_sweep(8'b1110_1000, 8'b1110_1000, 1'b0);

    // Random truth tables: exact matches and sparse corruptions.
    for (int t = 0; t < 10; t++) begin
      g = NV'($urandom);
      if (t % 2 == 0) r = g;
      else r = g ^ NV'($urandom & $urandom & $urandom);
      run_sweep(g, r, 1'b0);
    end
    g = NV'($urandom);
    run_sweep(g, ~g, 1'b0);

    // Small instance: identity function, matching and inverted golden.
    run_small(2'b10);
    run_small(2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/function_sweep_checker.md
FUNCTION_SWEEP_CHECKER -- requirements
Module: function_sweep_checker

Interface
REQ-001 Parameter N, default 3, number of function inputs; legal range 1..8.
REQ-002 Parameter SETTLE, default 1, idle cycles after each new vector before sampling; legal range 0..15.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  sweep request; sampled only in IDLE.
REQ-006 Port golden  input  2**N  expected truth table; bit i is the expected f for x==i.
REQ-007 Port f_in  input  1  DUT function output under test.
REQ-008 Port x  output  N  stimulus vector; MSB is x1, so {x1..xN}=index.
REQ-009 Port busy  output  1  high from the cycle after start is accepted through the last COMPARE.
REQ-010 Port done  output  1  one-cycle pulse at sweep end.
REQ-011 Port pass  output  1  high when the finished sweep had zero mismatches; held until next accepted start.
REQ-012 Port err_cnt  output  N+1  mismatch count of the current or last sweep.
REQ-013 Port first_fail  output  N  index of the first mismatching vector; valid when fail_valid=1.
REQ-014 Port fail_valid  output  1  high once a mismatch has been recorded in the current or last sweep.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, COMPARE and DONE.
REQ-016 In IDLE with start=1: latch golden; clear err_cnt, first_fail, fail_valid and pass; set x=0; go to SETTLE, or straight to COMPARE if SETTLE=0.
REQ-017 SETTLE SHALL hold x stable for exactly SETTLE cycles, then go to COMPARE.
REQ-018 COMPARE, one cycle: compare f_in with latched golden[x]. On mismatch, err_cnt+1, and on the first mismatch load first_fail=x and set fail_valid=1.
REQ-019 Leaving COMPARE: if x==2**N-1 go to DONE, else x+1 and go to SETTLE (or COMPARE if SETTLE=0).
REQ-020 Per-vector timing is SETTLE+1 cycles. With start accepted at edge k, done is high in cycle k+1+2**N*(SETTLE+1).
REQ-021 DONE, one cycle: done=1, busy=0, pass=(err_cnt==0); then go to IDLE.
REQ-022 x SHALL never wrap; after the sweep it holds the last compared vector until the next accepted start.
REQ-023 start SHALL be ignored in SETTLE, COMPARE and DONE, including a start coincident with done.
REQ-024 Changes on golden after acceptance SHALL be ignored for the rest of that sweep.
REQ-025 err_cnt SHALL NOT overflow; N+1 bits holds 2**N.

Reset
REQ-026 rst_n low SHALL immediately force x=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_valid=0 and state=IDLE, including mid-sweep.
REQ-027 After rst_n deasserts, the block SHALL wait in IDLE for a new start; no partial sweep resumes.

Configuration
REQ-028 Macro SWEEP_STOP_ON_FAIL_EN defined: the first mismatch SHALL go from COMPARE directly to DONE, with err_cnt=1 and x holding the failing vector.
REQ-029 Macro SWEEP_STOP_ON_FAIL_EN undefined: the full 2**N sweep SHALL always run.

Structure
REQ-030 Package sweep_pkg SHALL hold the state enum typedef (IDLE, SETTLE, COMPARE, DONE), N_MAX=8, SETTLE_MAX=15 and the default parameter values.
REQ-031 The settle down-counter SHALL be a sub-module, sweep_settle_timer (load, count, expire).

Verification (N=3, SETTLE=1 unless noted; start accepted at edge k)
REQ-032 golden=8'b1110_1000 (majority), f_in driven by an ideal majority model -> done at k+17, pass=1, err_cnt=0, fail_valid=0.
REQ-033 Same golden, f_in stuck at 0 -> err_cnt=4, first_fail=3, fail_valid=1, pass=0, done at k+17.
REQ-034 start re-pulsed at k+5 during the sweep -> ignored; single done at k+17, results as in REQ-032.
REQ-035 rst_n pulsed low at k+9 -> all outputs 0 at once; a later start gives a clean sweep, done 17 cycles later.
REQ-036 SWEEP_STOP_ON_FAIL_EN defined, f_in stuck at 0 -> done at k+9, err_cnt=1, first_fail=3, x=3, pass=0.
REQ-037 N=1, SETTLE=0, golden=2'b10, f_in=x -> done at k+3, pass=1.
